// File: rtl/fpga_game_pkg.sv
// Shared constants, selection FSM encoding and one-hot helpers for the game input front end.
package fpga_game_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;

    localparam int unsigned KEY_SELECT = 0;
    localparam int unsigned KEY_START  = 1;
    localparam int unsigned KEY_QUIT   = 3;

    localparam int unsigned NUM_TILES   = 10;
    localparam int unsigned TILE_IDX_W  = 4;

    typedef enum logic [0:0] {
        StIdle    = 1'b0,
        StPending = 1'b1
    } sel_state_e;

    function automatic logic is_onehot(input logic [NUM_TILES-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < NUM_TILES; i++) begin
            n += 32'(v[i]);
        end
        return (n == 1);
    endfunction

    function automatic logic [TILE_IDX_W-1:0] onehot_index(input logic [NUM_TILES-1:0] v);
        logic [TILE_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            if (v[i]) idx = TILE_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/debounce.sv
// Single-bit two-flop synchronizer followed by a stability counter; the accepted
// level only flips after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic        RESET_VAL       = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic dout_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            acc_q   <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any agreement between input and accepted level restarts the stability count.
    always_comb begin
        acc_d = acc_q;
        cnt_d = '0;
        if (sync2_q != acc_q) begin
            if (cnt_q == CntMax) begin
                acc_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign dout_o = acc_q;

endmodule

// File: rtl/fpga_input.sv
// Board input conditioning (debounced keys, switches) and tile-selection handshake.
// Define SW_DEBOUNCE_EN to debounce the slide switches as well as the keys.
module fpga_input
    import fpga_game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [3:0]            KEY,
    input  logic [NUM_TILES-1:0]  SW,
    output logic [3:0]            key_press,
    output logic [NUM_TILES-1:0]  sw_state,
    output logic                  tile_valid,
    output logic [TILE_IDX_W-1:0] tile_index,
    input  logic                  tile_ack,
    output logic                  sel_error,
    output logic                  overrun,
    output logic                  userquit
);

    logic [3:0] key_acc;
    logic [3:0] key_prev_q;
    logic [3:0] key_press_q;

    for (genvar i = 0; i < 4; i++) begin : g_key_db
        debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VAL      (1'b1)
        ) u_key_db (
            .clk_i (CLOCK_50),
            .rst_i (reset),
            .din_i (KEY[i]),
            .dout_o(key_acc[i])
        );
    end

`ifdef SW_DEBOUNCE_EN
    for (genvar i = 0; i < NUM_TILES; i++) begin : g_sw_db
        debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VAL      (1'b0)
        ) u_sw_db (
            .clk_i (CLOCK_50),
            .rst_i (reset),
            .din_i (SW[i]),
            .dout_o(sw_state[i])
        );
    end
`else
    logic [NUM_TILES-1:0] sw_sync1_q, sw_sync2_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
        end else begin
            sw_sync1_q <= SW;
            sw_sync2_q <= sw_sync1_q;
        end
    end

    assign sw_state = sw_sync2_q;
`endif

    // Keys are active-low, so a press is a falling edge of the accepted level.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            key_prev_q  <= 4'hF;
            key_press_q <= 4'h0;
        end else begin
            key_prev_q  <= key_acc;
            key_press_q <= key_prev_q & ~key_acc;
        end
    end

    assign key_press = key_press_q;
    assign userquit  = key_press_q[KEY_QUIT];

    sel_state_e            state_q, state_d;
    logic [TILE_IDX_W-1:0] tile_index_q;
    logic                  sel_press;
    logic                  sw_onehot;
    logic                  load;

    assign sel_press = key_press_q[KEY_SELECT];
    assign sw_onehot = is_onehot(sw_state);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            tile_index_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) tile_index_q <= onehot_index(sw_state);
        end
    end

    // An ack coinciding with a press frees the slot first, so the press is judged as from idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (sel_press && sw_onehot) state_d = StPending;
            StPending: if (tile_ack) state_d = (sel_press && sw_onehot) ? StPending : StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        load      = 1'b0;
        sel_error = 1'b0;
        overrun   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sel_press) begin
                    load      = sw_onehot;
                    sel_error = ~sw_onehot;
                end
            end
            StPending: begin
                if (sel_press) begin
                    if (tile_ack) begin
                        load      = sw_onehot;
                        sel_error = ~sw_onehot;
                    end else begin
                        overrun = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign tile_valid = (state_q == StPending);
    assign tile_index = tile_index_q;

endmodule

// File: doc/fpga_input.md
FPGA_INPUT -- requirements
Module: fpga_input

Interface
REQ-001 SHALL take parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable cycles required to accept an input change (10 ms at 50 MHz).
REQ-002 SHALL have port CLOCK_50  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port KEY  in  4  raw pushbuttons, active-low (0 = pressed), asynchronous to CLOCK_50.
REQ-005 SHALL have port SW  in  10  raw slide switches, active-high, asynchronous.
REQ-006 SHALL have port key_press  out  4  one-cycle pulse per key on debounced press.
REQ-007 SHALL have port sw_state  out  10  conditioned switch levels.
REQ-008 SHALL have port tile_valid  out  1  a tile selection is pending.
REQ-009 SHALL have port tile_index  out  4  selected tile, 0-9.
REQ-010 SHALL have port tile_ack  in  1  consumer accepts pending selection.
REQ-011 SHALL have port sel_error  out  1  one-cycle pulse, select with zero or multiple switches up.
REQ-012 SHALL have port overrun  out  1  one-cycle pulse, select while tile_valid already high.
REQ-013 SHALL have port userquit  out  1  one-cycle pulse on debounced KEY[3] press, same cycle as key_press[3].

Function
REQ-014 Every KEY and SW bit SHALL pass through a two-flop synchronizer before any other logic.
REQ-015 Per-bit debounce: counter clears when synchronized value equals accepted value; increments otherwise; accepted value flips and counter clears when counter reaches DEBOUNCE_CYCLES-1.
REQ-016 Glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change the accepted value.
REQ-017 key_press[i] SHALL pulse for exactly one cycle, the cycle after accepted KEY[i] goes 1->0; release produces no pulse.
REQ-018 Latency raw-edge to key_press SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles for a clean edge.
REQ-019 Counter width SHALL be clog2(DEBOUNCE_CYCLES) bits; counter SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-020 Selection FSM states: IDLE, PENDING.
REQ-021 IDLE + key_press[0] + sw_state exactly one-hot: tile_index <= bit position, go PENDING, tile_valid high next cycle.
REQ-022 IDLE + key_press[0] + sw_state zero or multi-hot: pulse sel_error, remain IDLE, tile_index unchanged.
REQ-023 PENDING + tile_ack: go IDLE, tile_valid low next cycle; tile_index holds last value.
REQ-024 PENDING + key_press[0] without tile_ack: pulse overrun, pending selection kept unchanged.
REQ-025 PENDING + key_press[0] + tile_ack same cycle: ack wins, new press evaluated per REQ-021/022 in that same cycle (back-to-back accept, tile_valid stays high if valid).
REQ-026 tile_ack in IDLE SHALL be ignored.
REQ-027 key_press[1], key_press[2] are forwarded only; no internal state.

Reset
REQ-028 Reset SHALL force: synchronizers and accepted KEY to 1 (released), accepted SW to 0, counters 0, FSM IDLE.
REQ-029 During and after reset: key_press 0, sw_state 0, tile_valid 0, tile_index 0, sel_error 0, overrun 0, userquit 0.
REQ-030 Key held during reset release SHALL produce key_press after normal debounce latency; pending selection SHALL be dropped by reset mid-operation.

Configuration
REQ-031 With SW_DEBOUNCE_EN defined, SW bits SHALL use full debounce per REQ-015.
REQ-032 Without SW_DEBOUNCE_EN, sw_state SHALL equal the two-flop synchronized SW (latency 2 cycles); KEY debounce unaffected.

Structure
REQ-033 Shared package fpga_game_pkg SHALL hold DEBOUNCE_CYCLES default, key indices KEY_SELECT=0, KEY_START=1, KEY_QUIT=3, NUM_TILES=10, FSM state encoding.
REQ-034 One sub-module debounce (single-bit synchronizer + counter + accepted flop, parameter DEBOUNCE_CYCLES, reset value parameter) SHALL be instantiated per debounced input.

Verification (DEBOUNCE_CYCLES=4)
REQ-035 KEY[0] 1->0 held 20 cycles -> key_press[0] single pulse at cycle 7 after edge; no pulse on release.
REQ-036 KEY[2] low for 3 cycles then high -> no key_press[2], no change ever.
REQ-037 SW=10'b0000100000, press KEY[0] -> tile_valid=1, tile_index=5 until tile_ack; one cycle after ack tile_valid=0.
REQ-038 SW=10'b0000000011 then press KEY[0] -> sel_error one pulse, tile_valid stays 0; SW=0 press -> sel_error again.
REQ-039 Pending index 5, SW changed to bit 2, press without ack -> overrun pulse, index 5 retained; press coincident with tile_ack -> tile_index=2, tile_valid stays 1.
REQ-040 KEY[3] press -> userquit and key_press[3] coincident pulses; assert reset while PENDING -> all outputs 0 within same cycle.
